// File: rtl/rr_demux_dispatcher_pkg.sv
// rtl/rr_demux_dispatcher_pkg.sv - shared state encoding and round-robin pick helper
package rr_demux_dispatcher_pkg;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_HOLD = 1'b1;

  typedef enum logic {
    ST_IDLE = S_IDLE,
    ST_HOLD = S_HOLD
  } state_t;

  // First enabled index at or after start, wrapping mod 4; descending loop so the
  // smallest offset from start is the last (winning) assignment.
  function automatic logic [1:0] rr_pick(input logic [3:0] en, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (en[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_demux_dispatcher_demux.sv
// rtl/rr_demux_dispatcher_demux.sv - 1-to-4 demultiplexer driving the one-hot consumer valids
module b1to4_demuxer (
  input  logic       x0,
  input  logic [1:0] b1_b0,
  output logic [3:0] z3_z0
);

  always_comb begin
    z3_z0 = 4'b0000;
    if (x0) z3_z0[b1_b0] = 1'b1;
  end

endmodule

// File: rtl/rr_demux_dispatcher.sv
// rtl/rr_demux_dispatcher.sv - round-robin dispatcher of one valid/ready stream to four consumers
module rr_demux_dispatcher
  import rr_demux_dispatcher_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [3:0]    enable,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [W-1:0]  out_data,
  output logic [1:0]    sel,
  output logic          busy,
  output logic [CW-1:0] count
);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] count_q, count_d;

  logic       holding;
  logic       fire_o;
  logic       fire_i;
  logic [1:0] start;
  logic [1:0] pick;

  assign holding  = (state_q == ST_HOLD);
  assign fire_o   = holding && out_ready[sel_q];
  assign in_ready = (!holding || fire_o) && (enable != 4'b0000);
  assign fire_i   = in_valid && in_ready;

  // While holding, a new word is only taken alongside fire_o, so search from sel+1.
  assign start = holding ? (sel_q + 2'd1) : ptr_q;
  assign pick  = rr_pick(enable, start);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    count_d = count_q;
    if (fire_o) begin
      count_d = count_q + CW'(1);
      state_d = ST_IDLE;
      ptr_d   = sel_q + 2'd1;
    end
    if (fire_i) begin
      state_d = ST_HOLD;
      sel_d   = pick;
      data_d  = in_data;
      if (fire_o) ptr_d = pick + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  b1to4_demuxer u_demux (
    .x0    (holding),
    .b1_b0 (sel_q),
    .z3_z0 (out_valid)
  );

  assign out_data = data_q;
  assign sel      = sel_q;
  assign busy     = holding;
  assign count    = count_q;

endmodule

// File: tb/tb_rr_demux_dispatcher.sv
// tb/tb_rr_demux_dispatcher.sv - directed scoreboard bench for rr_demux_dispatcher
module tb_rr_demux_dispatcher;

  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [3:0] enable = 4'b1111;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'b1111;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] count;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];

  rr_demux_dispatcher #(.W(8), .CW(4)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .enable    (enable),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] v;
    v = 4'b0000;
    v[i] = 1'b1;
    return v;
  endfunction

  // Output-side scoreboard: every consumer handshake pops the oldest expectation.
  always @(negedge clock) begin
    logic [9:0] e;
    if (reset_ && ((out_valid & out_ready) != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {28'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_valid", {28'd0, out_valid}, {28'd0, onehot(e[9:8])});
        check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic send(input logic [7:0] d, input int cons);
    int n;
    logic [1:0] c;
    c = cons[1:0];
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back({c, d});
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] held;
    // Reset state
    #12;
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    reset_ = 1'b1;

    // 1: full enable, streamed back to back
    send(8'hA1, 0);
    send(8'hB2, 1);
    send(8'hC3, 2);
    send(8'hD4, 3);
    drain();
    check("t1_count", {28'd0, count}, 32'd4);

    // 2: only consumers 1 and 3 eligible
    enable = 4'b1010;
    send(8'h11, 1);
    send(8'h22, 3);
    send(8'h33, 1);
    drain();
    check("t2_count", {28'd0, count}, 32'd7);

    // 3: consumer 2 stalls for 5 cycles
    enable = 4'b1111;
    out_ready = 4'b1011;
    send(8'h5A, 2);
    in_valid = 1'b1;
    in_data = 8'h6B;
    held = out_data;
    check("t3_held_data", {24'd0, held}, 32'h5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_stall_valid", {28'd0, out_valid}, 32'b0100);
      check("t3_stall_data", {24'd0, out_data}, {24'd0, held});
      check("t3_stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clock);
    #1;
    out_ready = 4'b1111;
    send(8'h6B, 3);
    drain();
    check("t3_count", {28'd0, count}, 32'd9);

    // 4: enable dropped while a word for consumer 1 is held
    out_ready = 4'b0000;
    enable = 4'b0010;
    send(8'h77, 1);
    enable = 4'b0000;
    @(negedge clock);
    check("t4_busy", {31'd0, busy}, 32'd1);
    check("t4_sel", {30'd0, sel}, 32'd1);
    check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    out_ready = 4'b0010;
    drain();
    @(negedge clock);
    check("t4_after_busy", {31'd0, busy}, 32'd0);
    check("t4_after_in_ready", {31'd0, in_ready}, 32'd0);
    check("t4_count", {28'd0, count}, 32'd10);

    // 5: asynchronous reset while holding
    @(posedge clock);
    #1;
    enable = 4'b1111;
    out_ready = 4'b0000;
    send(8'h99, 2);
    check("t5_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_ = 1'b0;
    #1;
    check("t5_rst_valid", {28'd0, out_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_count", {28'd0, count}, 32'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_ = 1'b1;
    out_ready = 4'b1111;
    send(8'h01, 0);
    drain();
    check("t5_count", {28'd0, count}, 32'd1);

    // 6: counter wrap at 2^CW-1
    for (int i = 0; i < 14; i++) send(8'(8'h40 + i), (1 + i) % 4);
    drain();
    check("t6_count_max", {28'd0, count}, 32'd15);
    send(8'hEE, 3);
    drain();
    check("t6_count_wrap", {28'd0, count}, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
